calc_job_scheduler: RTL and testbench

//  Shares one combinational MOSFET calculator core (opt[2:0], in_n0..in_n4 -> out_n[9:0]) between two requesters.

---
 rtl/calc_job_scheduler.sv | 132 +++++++++++++
 tb/tb_calc_job_scheduler.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_job_scheduler.sv
// Round-robin scheduler sharing one combinational calculator core between two requesters.
// Optional per-requester completion counters are enabled by defining CALC_SCHED_STATS_EN.
//
// state   | meaning
// IDLE    | arbitrating, a requester may be accepted this cycle
// WAIT    | operands on the core, latency down-counter running
// RESP    | result held on the response port until out_ready
module calc_job_scheduler #(
    parameter int CALC_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [2:0]  req0_opt,
    input  logic [19:0] req0_n,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [2:0]  req1_opt,
    input  logic [19:0] req1_n,
    output logic [2:0]  calc_opt,
    output logic [3:0]  calc_in_n0,
    output logic [3:0]  calc_in_n1,
    output logic [3:0]  calc_in_n2,
    output logic [3:0]  calc_in_n3,
    output logic [3:0]  calc_in_n4,
    input  logic [9:0]  calc_out_n,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [9:0]  out_n,
    output logic        out_id,
`ifdef CALC_SCHED_STATS_EN
    output logic [15:0] job_cnt0,
    output logic [15:0] job_cnt1,
`endif
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam logic [3:0] LAT_LOAD = 4'(CALC_LAT);

    state_t      state;
    logic        prio;
    logic [3:0]  lat_cnt;
    logic        grant_id;
    logic        any_valid;
    logic        accept;
    logic [2:0]  sel_opt;
    logic [19:0] sel_n;

    always_comb begin
        any_valid  = req0_valid | req1_valid;
        grant_id   = (req0_valid && req1_valid) ? prio : req1_valid;
        // ready is suppressed while reset is asserted so no handshake is seen by a requester
        req0_ready = !rst && (state == ST_IDLE) && any_valid && !grant_id;
        req1_ready = !rst && (state == ST_IDLE) && any_valid && grant_id;
        accept     = req0_ready | req1_ready;
        sel_opt    = grant_id ? req1_opt : req0_opt;
        sel_n      = grant_id ? req1_n : req0_n;
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            prio       <= 1'b0;
            lat_cnt    <= '0;
            calc_opt   <= '0;
            calc_in_n0 <= '0;
            calc_in_n1 <= '0;
            calc_in_n2 <= '0;
            calc_in_n3 <= '0;
            calc_in_n4 <= '0;
            out_valid  <= 1'b0;
            out_n      <= '0;
            out_id     <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        calc_opt   <= sel_opt;
                        calc_in_n0 <= sel_n[3:0];
                        calc_in_n1 <= sel_n[7:4];
                        calc_in_n2 <= sel_n[11:8];
                        calc_in_n3 <= sel_n[15:12];
                        calc_in_n4 <= sel_n[19:16];
                        out_id     <= grant_id;
                        prio       <= ~grant_id;
                        lat_cnt    <= LAT_LOAD;
                        state      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (lat_cnt == 4'd1) begin
                        out_n     <= calc_out_n;
                        out_valid <= 1'b1;
                        lat_cnt   <= '0;
                        state     <= ST_RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef CALC_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            job_cnt0 <= '0;
            job_cnt1 <= '0;
        end else if (out_valid && out_ready) begin
            if (out_id) job_cnt1 <= job_cnt1 + 16'd1;
            else        job_cnt0 <= job_cnt0 + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_calc_job_scheduler.sv
// Bench for calc_job_scheduler: directed steps plus randomized traffic against a transaction-level model.
// Build with CALC_SCHED_STATS_EN defined to also cover the completion counters.
module tb_calc_job_scheduler;

    localparam int LAT = 1;

    logic        clk;
    logic        rst;
    logic        v0, v1, r0, r1;
    logic [2:0]  o0, o1;
    logic [19:0] n0, n1;
    logic [2:0]  calc_opt;
    logic [3:0]  cn0, cn1, cn2, cn3, cn4;
    logic [9:0]  calc_out_n;
    logic        out_valid, ordy, out_id, busy;
    logic [9:0]  out_n;
`ifdef CALC_SCHED_STATS_EN
    logic [15:0] job_cnt0, job_cnt1;
`endif

    // second instance with a longer core latency
    logic        rst4;
    logic        b_v0, b_v1, b_r0, b_r1;
    logic [2:0]  b_o0, b_o1;
    logic [19:0] b_n0, b_n1;
    logic [2:0]  b_copt;
    logic [3:0]  b_cn0, b_cn1, b_cn2, b_cn3, b_cn4;
    logic [9:0]  b_calc_out_n;
    logic        b_out_valid, b_ordy, b_out_id, b_busy;
    logic [9:0]  b_out_n;
`ifdef CALC_SCHED_STATS_EN
    logic [15:0] b_job_cnt0, b_job_cnt1;
`endif

    int checks = 0;
    int errors = 0;

    // behavioural calculator core: arbitrary per-opt function with signed 10b results
    function automatic logic [9:0] core_model(input logic [2:0] opt, input logic [19:0] n);
        int a0, a1, a2, a3, a4, r;
        a0 = int'(n[3:0]);   a1 = int'(n[7:4]);   a2 = int'(n[11:8]);
        a3 = int'(n[15:12]); a4 = int'(n[19:16]);
        case (opt)
            3'd0: r = a0 + a4;
            3'd1: r = a0 * a1 - a2 * a3;
            3'd2: r = a2 * a3 * a4 - 300;
            3'd3: r = -(a1 * a2) - a3;
            3'd4: r = a2 + a3;
            3'd5: r = a0 - a1 - a2 - a3 - a4;
            3'd6: r = a0 * a1 * a4;
            default: r = -512 + a0;
        endcase
        return r[9:0];
    endfunction

    assign calc_out_n   = core_model(calc_opt, {cn4, cn3, cn2, cn1, cn0});
    assign b_calc_out_n = core_model(b_copt, {b_cn4, b_cn3, b_cn2, b_cn1, b_cn0});

    calc_job_scheduler #(.CALC_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_ready(r0), .req0_opt(o0), .req0_n(n0),
        .req1_valid(v1), .req1_ready(r1), .req1_opt(o1), .req1_n(n1),
        .calc_opt(calc_opt), .calc_in_n0(cn0), .calc_in_n1(cn1), .calc_in_n2(cn2),
        .calc_in_n3(cn3), .calc_in_n4(cn4), .calc_out_n(calc_out_n),
        .out_valid(out_valid), .out_ready(ordy), .out_n(out_n), .out_id(out_id),
`ifdef CALC_SCHED_STATS_EN
        .job_cnt0(job_cnt0), .job_cnt1(job_cnt1),
`endif
        .busy(busy)
    );

    calc_job_scheduler #(.CALC_LAT(4)) dut4 (
        .clk(clk), .rst(rst4),
        .req0_valid(b_v0), .req0_ready(b_r0), .req0_opt(b_o0), .req0_n(b_n0),
        .req1_valid(b_v1), .req1_ready(b_r1), .req1_opt(b_o1), .req1_n(b_n1),
        .calc_opt(b_copt), .calc_in_n0(b_cn0), .calc_in_n1(b_cn1), .calc_in_n2(b_cn2),
        .calc_in_n3(b_cn3), .calc_in_n4(b_cn4), .calc_out_n(b_calc_out_n),
        .out_valid(b_out_valid), .out_ready(b_ordy), .out_n(b_out_n), .out_id(b_out_id),
`ifdef CALC_SCHED_STATS_EN
        .job_cnt0(b_job_cnt0), .job_cnt1(b_job_cnt1),
`endif
        .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // transaction-level model: a job is either absent, counting down its latency, or awaiting pickup
    bit          m_idle = 1'b1;
    bit          m_resp = 1'b0;
    bit          m_prio = 1'b0;
    int          m_left = 0;
    logic [2:0]  m_copt = '0;
    logic [19:0] m_cn = '0;
    logic [9:0]  m_out = '0;
    bit          m_id = 1'b0;
    logic [15:0] m_cnt0 = '0;
    logic [15:0] m_cnt1 = '0;
    int          grants[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one clock: compare outputs with the model, advance the model across the edge
    task automatic tick();
        bit er0, er1;
        int acc;
        #1;
        er0 = !rst && m_idle && v0 && (!v1 || !m_prio);
        er1 = !rst && m_idle && v1 && (!v0 || m_prio);
        chk("req0_ready", r0, er0);
        chk("req1_ready", r1, er1);
        chk("out_valid", out_valid, m_resp);
        chk("busy", busy, !m_idle);
        chk("calc_opt", calc_opt, m_copt);
        chk("calc_n", {cn4, cn3, cn2, cn1, cn0}, m_cn);
        if (m_resp) begin
            chk("out_n", out_n, m_out);
            chk("out_id", out_id, m_id);
        end
`ifdef CALC_SCHED_STATS_EN
        chk("job_cnt0", job_cnt0, m_cnt0);
        chk("job_cnt1", job_cnt1, m_cnt1);
`endif
        acc = -1;
        if (rst) begin
            m_idle = 1'b1; m_resp = 1'b0; m_prio = 1'b0; m_left = 0;
            m_copt = '0; m_cn = '0; m_id = 1'b0; m_cnt0 = '0; m_cnt1 = '0;
        end else if (m_idle) begin
            if (er0 || er1) begin
                acc    = er1 ? 1 : 0;
                m_id   = er1;
                m_copt = er1 ? o1 : o0;
                m_cn   = er1 ? n1 : n0;
                m_prio = !er1;
                m_left = LAT;
                m_idle = 1'b0;
                grants.push_back(acc);
            end
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_resp = 1'b1;
                m_out  = core_model(m_copt, m_cn);
            end
        end else if (m_resp && ordy) begin
            m_resp = 1'b0;
            m_idle = 1'b1;
            if (m_id) m_cnt1 = m_cnt1 + 16'd1;
            else      m_cnt0 = m_cnt0 + 16'd1;
        end
        @(posedge clk);
        @(negedge clk);
        if (acc == 0) v0 = 1'b0;
        if (acc == 1) v1 = 1'b0;
    endtask

    task automatic job(input bit id, input logic [2:0] opt);
        if (id) begin v1 = 1'b1; o1 = opt; n1 = 20'($urandom); end
        else    begin v0 = 1'b1; o0 = opt; n0 = 20'($urandom); end
    endtask

    initial begin
        int k;
        rst = 1'b1; v0 = 1'b1; v1 = 1'b1; o0 = 3'd1; o1 = 3'd2;
        n0 = 20'h12345; n1 = 20'h54321; ordy = 1'b1;
        rst4 = 1'b1; b_v0 = 1'b0; b_v1 = 1'b0; b_o0 = '0; b_o1 = '0;
        b_n0 = '0; b_n1 = '0; b_ordy = 1'b1;
        @(posedge clk);
        @(negedge clk);

        // reset held with both requesters valid
        repeat (3) tick();
        chk("rst_calc_opt", calc_opt, 3'd0);
        chk("rst_out_n", out_n, 10'd0);

        // single job from requester 0: opt 0, operands 1..5
        rst = 1'b0; v0 = 1'b1; v1 = 1'b0; o0 = 3'd0;
        n0 = {4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
        #1 chk("t2_ready0", r0, 1'b1);
        tick();
        chk("t2_wait_valid", out_valid, 1'b0);
        tick();
        chk("t2_valid", out_valid, 1'b1);
        chk("t2_out_n", out_n, 10'd6);
        chk("t2_out_id", out_id, 1'b0);
        tick();

        // single job from requester 1: opt 4, operands 1..5
        v1 = 1'b1; o1 = 3'd4; n1 = {4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
        tick();
        tick();
        chk("t3_out_n", out_n, 10'd7);
        chk("t3_out_id", out_id, 1'b1);
        tick();

        // both requesters valid continuously right after reset
        rst = 1'b1; tick(); rst = 1'b0;
        grants.delete();
        for (int i = 0; i < 16; i++) begin
            if (!v0) job(1'b0, 3'($urandom));
            if (!v1) job(1'b1, 3'($urandom));
            tick();
        end
        for (int i = 0; i < grants.size(); i++) chk("t4_grant", grants[i], i % 2);
        chk("t4_grant_count", grants.size(), 16 / (LAT + 2) + ((16 % (LAT + 2)) != 0));

        // response back-pressure for 10 cycles
        while (!m_idle) tick();
        v1 = 1'b0;
        job(1'b0, 3'd1);
        ordy = 1'b0;
        tick(); tick();
        job(1'b1, 3'd3);
        v0 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t5_hold_valid", out_valid, 1'b1);
        end
        ordy = 1'b1;
        tick();
        chk("t5_released", busy, 1'b0);
        while (!m_idle || v0 || v1) tick();

        // reset while the job is in WAIT discards it
        job(1'b0, 3'd6);
        tick();
        chk("t6_busy", busy, 1'b1);
        rst = 1'b1; v0 = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t6_no_valid", out_valid, 1'b0);
        end

        // randomized traffic, protocol drops, back-pressure and rare resets
        for (int i = 0; i < 400; i++) begin
            if (!v0 && $urandom_range(0, 2) == 0) job(1'b0, 3'($urandom));
            else if (v0 && $urandom_range(0, 9) == 0) v0 = 1'b0;
            if (!v1 && $urandom_range(0, 2) == 0) job(1'b1, 3'($urandom));
            else if (v1 && $urandom_range(0, 9) == 0) v1 = 1'b0;
            ordy = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0; v0 = 1'b0; v1 = 1'b0; ordy = 1'b1;
        repeat (LAT + 3) tick();

        // five completions after reset: ids 0,0,1,0,1
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            job((i == 2 || i == 4), 3'($urandom));
            repeat (LAT + 2) tick();
        end
        tick();
        chk("stat_model0", m_cnt0, 16'd3);
        chk("stat_model1", m_cnt1, 16'd2);
`ifdef CALC_SCHED_STATS_EN
        chk("stat_cnt0", job_cnt0, 16'd3);
        chk("stat_cnt1", job_cnt1, 16'd2);
`endif

        // latency 4 instance: response exactly 4 cycles after acceptance
        rst4 = 1'b0;
        b_v1 = 1'b1; b_o1 = 3'd4; b_n1 = {4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
        #1 chk("lat4_ready1", b_r1, 1'b1);
        @(posedge clk);
        #1 b_v1 = 1'b0;
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (b_out_valid) begin
                k = i;
                break;
            end
            chk("lat4_busy", b_busy, 1'b1);
        end
        chk("lat4_cycles", k, 4);
        chk("lat4_out_n", b_out_n, 10'd7);
        chk("lat4_out_id", b_out_id, 1'b1);
        @(posedge clk);
        #1 chk("lat4_done", b_out_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
